// File: rtl/speicher_arbiter_if.sv
// Bus bundle between the shared-RAM arbiter, its two requesters (fetch, data) and the RAM.
// The master modport is the arbiter's view; slave is the requester/RAM side.
interface speicher_arbiter_if #(
  parameter int WORDSIZE     = 32,
  parameter int ADRESSBREITE = 8
);
  logic                    InstrLesen;
  logic [ADRESSBREITE-1:0] InstrAdresse;
  logic [WORDSIZE-1:0]     InstrDaten;
  logic                    InstrGeladen;

  logic                    DatenLesen;
  logic                    DatenSchreiben;
  logic [ADRESSBREITE-1:0] DatenAdresse;
  logic [WORDSIZE-1:0]     DatenSchreibwert;
  logic [WORDSIZE-1:0]     DatenLesewert;
  logic                    DatenGeladen;
  logic                    DatenGespeichert;

  logic                    RAMLesenAn;
  logic                    RAMSchreibenAn;
  logic [ADRESSBREITE-1:0] RAMAdresse;
  logic [WORDSIZE-1:0]     RAMDatenRein;
  logic [WORDSIZE-1:0]     RAMDatenRaus;
  logic                    RAMDatenBereit;
  logic                    RAMDatenGeschrieben;

  logic                    Zeitueberschreitung;

  modport master (
    input  InstrLesen, InstrAdresse,
    output InstrDaten, InstrGeladen,
    input  DatenLesen, DatenSchreiben, DatenAdresse, DatenSchreibwert,
    output DatenLesewert, DatenGeladen, DatenGespeichert,
    output RAMLesenAn, RAMSchreibenAn, RAMAdresse, RAMDatenRein,
    input  RAMDatenRaus, RAMDatenBereit, RAMDatenGeschrieben,
    output Zeitueberschreitung
  );

  modport slave (
    output InstrLesen, InstrAdresse,
    input  InstrDaten, InstrGeladen,
    output DatenLesen, DatenSchreiben, DatenAdresse, DatenSchreibwert,
    input  DatenLesewert, DatenGeladen, DatenGespeichert,
    input  RAMLesenAn, RAMSchreibenAn, RAMAdresse, RAMDatenRein,
    output RAMDatenRaus, RAMDatenBereit, RAMDatenGeschrieben,
    input  Zeitueberschreitung
  );
endinterface

// File: rtl/speicher_arbiter.sv
// Arbitrates a single-ported RAM between instruction fetch and data access with
// round-robin on conflict and a per-access acknowledge timeout.
module speicher_arbiter #(
  parameter int WORDSIZE     = 32,
  parameter int ADRESSBREITE = 8,
  parameter int TIMEOUT      = 15
) (
  input  logic                Clock,
  input  logic                Reset,
  speicher_arbiter_if.master  bus
);
  localparam int          CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {FREI, ZUGRIFF, ABSCHLUSS} zustand_t;

  zustand_t                zustand, folge;
  logic                    letzter;      // 1: data port was granted last
  logic                    dienerDaten;  // 1: current access belongs to the data port
  logic                    istSchreiben;
  logic                    timeoutFlag;
  logic [CW-1:0]           zaehler;
  logic [ADRESSBREITE-1:0] adresse;
  logic [WORDSIZE-1:0]     schreibwert, instrDaten, datenLesewert;

  logic anyReq, datenReq, gewinnerDaten, ack, abgelaufen;

  always_comb begin
    datenReq      = bus.DatenLesen | bus.DatenSchreiben;
    anyReq        = bus.InstrLesen | datenReq;
    gewinnerDaten = datenReq & (~bus.InstrLesen | ~letzter);
    ack           = istSchreiben ? bus.RAMDatenGeschrieben : bus.RAMDatenBereit;
    abgelaufen    = (zaehler == LIMIT);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) zustand <= FREI;
    else        zustand <= folge;
  end

  always_comb begin
    folge = zustand;
    case (zustand)
      FREI:      if (anyReq) folge = ZUGRIFF;
      ZUGRIFF:   if (ack || abgelaufen) folge = ABSCHLUSS;
      ABSCHLUSS: folge = FREI;
      default:   folge = FREI;
    endcase
  end

  // An acknowledge wins over an expiring counter in the same cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      letzter       <= 1'b1;
      dienerDaten   <= 1'b0;
      istSchreiben  <= 1'b0;
      timeoutFlag   <= 1'b0;
      zaehler       <= '0;
      adresse       <= '0;
      schreibwert   <= '0;
      instrDaten    <= '0;
      datenLesewert <= '0;
    end else begin
      case (zustand)
        FREI: if (anyReq) begin
          letzter      <= gewinnerDaten;
          dienerDaten  <= gewinnerDaten;
          istSchreiben <= gewinnerDaten & bus.DatenSchreiben;
          adresse      <= gewinnerDaten ? bus.DatenAdresse : bus.InstrAdresse;
          if (gewinnerDaten) schreibwert <= bus.DatenSchreibwert;
          zaehler      <= '0;
          timeoutFlag  <= 1'b0;
        end
        ZUGRIFF: begin
          if (ack || abgelaufen) begin
            timeoutFlag <= ~ack;
            if (!istSchreiben) begin
              if (dienerDaten) datenLesewert <= ack ? bus.RAMDatenRaus : '0;
              else             instrDaten    <= ack ? bus.RAMDatenRaus : '0;
            end
          end else begin
            zaehler <= zaehler + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.RAMLesenAn          = (zustand == ZUGRIFF) & ~istSchreiben;
    bus.RAMSchreibenAn      = (zustand == ZUGRIFF) &  istSchreiben;
    bus.RAMAdresse          = adresse;
    bus.RAMDatenRein        = schreibwert;
    bus.InstrGeladen        = (zustand == ABSCHLUSS) & ~dienerDaten;
    bus.DatenGeladen        = (zustand == ABSCHLUSS) &  dienerDaten & ~istSchreiben;
    bus.DatenGespeichert    = (zustand == ABSCHLUSS) &  dienerDaten &  istSchreiben;
    bus.Zeitueberschreitung = (zustand == ABSCHLUSS) &  timeoutFlag;
    bus.InstrDaten          = instrDaten;
    bus.DatenLesewert       = datenLesewert;
  end
endmodule

// File: tb/tb_speicher_arbiter.sv
// Directed bench for speicher_arbiter: a RAM model checks strobes, a scoreboard checks done pulses.
module tb_speicher_arbiter;
  logic Clock, Reset;
  speicher_arbiter_if #(.WORDSIZE(32), .ADRESSBREITE(8)) bus();

  speicher_arbiter #(.WORDSIZE(32), .ADRESSBREITE(8), .TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // flags = {InstrGeladen, DatenGeladen, DatenGespeichert, Zeitueberschreitung}
  typedef struct {logic [3:0] flags; logic [31:0] data;} doneExp_t;
  typedef struct {logic wr; logic [7:0] addr; logic [31:0] wdata; int len;} ramExp_t;

  doneExp_t  doneQ[$];
  ramExp_t   ramQ[$];
  logic [31:0] mem [256];
  int ackDelay;
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expDone(input logic [3:0] f, input logic [31:0] d);
    doneExp_t e;
    e.flags = f; e.data = d;
    doneQ.push_back(e);
  endtask

  task automatic expRam(input logic wr, input logic [7:0] a, input logic [31:0] w, input int len);
    ramExp_t e;
    e.wr = wr; e.addr = a; e.wdata = w; e.len = len;
    ramQ.push_back(e);
  endtask

  // RAM model: acks in strobe cycle number ackDelay (0 = never)
  initial begin
    bit active = 0;
    int len = 0;
    ramExp_t cur;
    bus.RAMDatenBereit = 0; bus.RAMDatenGeschrieben = 0; bus.RAMDatenRaus = '0;
    forever begin
      @(negedge Clock);
      bus.RAMDatenBereit = 0; bus.RAMDatenGeschrieben = 0;
      if (!Reset) begin
        active = 0;
      end else if (bus.RAMLesenAn || bus.RAMSchreibenAn) begin
        if (!active) begin
          active = 1; len = 0;
          if (ramQ.size() == 0) begin
            check("unexpected ram strobe", 32'(bus.RAMAdresse), 32'hFFFF_FFFF);
            cur.wr = bus.RAMSchreibenAn; cur.addr = bus.RAMAdresse; cur.len = -1;
          end else begin
            cur = ramQ.pop_front();
            check("ram strobe type", {30'b0, bus.RAMSchreibenAn, bus.RAMLesenAn}, {30'b0, cur.wr, ~cur.wr});
            check("ram address", 32'(bus.RAMAdresse), 32'(cur.addr));
            if (cur.wr) check("ram write data", bus.RAMDatenRein, cur.wdata);
          end
        end
        len++;
        if (ackDelay != 0 && len == ackDelay) begin
          if (bus.RAMSchreibenAn) begin
            bus.RAMDatenGeschrieben = 1;
            mem[bus.RAMAdresse] = bus.RAMDatenRein;
          end else begin
            bus.RAMDatenBereit = 1;
            bus.RAMDatenRaus = mem[bus.RAMAdresse];
          end
        end
      end else if (active) begin
        active = 0;
        if (cur.len >= 0) check("strobe length", 32'(len), 32'(cur.len));
      end
    end
  end

  // scoreboard monitor on done pulses
  initial begin
    doneExp_t e;
    logic [3:0] f;
    forever begin
      @(negedge Clock);
      f = {bus.InstrGeladen, bus.DatenGeladen, bus.DatenGespeichert, bus.Zeitueberschreitung};
      if (f != 4'b0) begin
        if (doneQ.size() == 0) check("unexpected done", 32'(f), 32'h0);
        else begin
          e = doneQ.pop_front();
          check("done flags", 32'(f), 32'(e.flags));
          if (e.flags[3]) check("InstrDaten", bus.InstrDaten, e.data);
          if (e.flags[2]) check("DatenLesewert", bus.DatenLesewert, e.data);
        end
      end
    end
  end

  task automatic waitDone(input bit instr, input string name);
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge Clock);
      seen = instr ? bus.InstrGeladen : (bus.DatenGeladen | bus.DatenGespeichert);
    end
    if (!seen) begin
      vectors++; errors++;
      $display("FAIL %s: no done pulse within 80 cycles", name);
    end
    @(posedge Clock); #1;
  endtask

  task automatic fetch(input int n, input logic [7:0] a0);
    bus.InstrLesen = 1; bus.InstrAdresse = a0;
    for (int k = 0; k < n; k++) begin
      waitDone(1'b1, "fetch wait");
      bus.InstrAdresse = a0 + 8'(k + 1);
    end
    bus.InstrLesen = 0;
  endtask

  task automatic datenZugriff(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] w);
    bus.DatenLesen = rd; bus.DatenSchreiben = wr; bus.DatenAdresse = a; bus.DatenSchreibwert = w;
    waitDone(1'b0, "data wait");
    bus.DatenLesen = 0; bus.DatenSchreiben = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic resetPulse();
    @(posedge Clock); #1 Reset = 0;
    @(posedge Clock); #1 Reset = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h05] = 32'hDEADBEEF; mem[8'h20] = 32'h11111111;
    mem[8'h21] = 32'h33333333; mem[8'h30] = 32'h22222222;
    mem[8'h44] = 32'hAAAA5555;
    ackDelay = 2;
    Reset = 0;
    bus.InstrLesen = 0; bus.InstrAdresse = '0;
    bus.DatenLesen = 0; bus.DatenSchreiben = 0; bus.DatenAdresse = '0; bus.DatenSchreibwert = '0;
    #2;
    check("reset RAMLesenAn", 32'(bus.RAMLesenAn), 0);
    check("reset RAMSchreibenAn", 32'(bus.RAMSchreibenAn), 0);
    check("reset done pulses", 32'({bus.InstrGeladen, bus.DatenGeladen, bus.DatenGespeichert}), 0);
    check("reset Zeitueberschreitung", 32'(bus.Zeitueberschreitung), 0);
    check("reset RAMAdresse", 32'(bus.RAMAdresse), 0);
    check("reset RAMDatenRein", bus.RAMDatenRein, 0);
    check("reset InstrDaten", bus.InstrDaten, 0);
    check("reset DatenLesewert", bus.DatenLesewert, 0);
    @(posedge Clock); #1 Reset = 1;

    // plain fetch, ack in second strobe cycle
    expRam(0, 8'h05, 0, 2); expDone(4'b1000, 32'hDEADBEEF);
    fetch(1, 8'h05);
    idle(2);

    // conflicts after reset: fetch, data, then fetch loses the second conflict
    resetPulse();
    expRam(0, 8'h20, 0, 2); expDone(4'b1000, 32'h11111111);
    expRam(0, 8'h30, 0, 2); expDone(4'b0100, 32'h22222222);
    expRam(0, 8'h21, 0, 2); expDone(4'b1000, 32'h33333333);
    fork
      fetch(2, 8'h20);
      datenZugriff(1, 0, 8'h30, 0);
    join
    idle(2);

    // write with immediate ack, then read back
    ackDelay = 1;
    expRam(1, 8'h10, 32'h0000000F, 1); expDone(4'b0010, 0);
    datenZugriff(0, 1, 8'h10, 32'h0000000F);
    ackDelay = 2;
    expRam(0, 8'h10, 0, 2); expDone(4'b0100, 32'h0000000F);
    datenZugriff(1, 0, 8'h10, 0);
    idle(1);

    // no ack: abort after 15 strobe cycles, read data forced to 0
    ackDelay = 0;
    expRam(0, 8'h40, 0, 15); expDone(4'b0101, 32'h0);
    datenZugriff(1, 0, 8'h40, 0);
    idle(1);

    // ack in the 15th cycle still succeeds
    ackDelay = 15;
    expRam(0, 8'h44, 0, 15); expDone(4'b0100, 32'hAAAA5555);
    datenZugriff(1, 0, 8'h44, 0);
    idle(1);

    // reset in the middle of an access
    ackDelay = 0;
    expRam(0, 8'h50, 0, -1);
    bus.DatenLesen = 1; bus.DatenAdresse = 8'h50;
    repeat (4) @(posedge Clock);
    #2 Reset = 0;
    #1;
    check("mid reset RAMLesenAn", 32'(bus.RAMLesenAn), 0);
    check("mid reset RAMSchreibenAn", 32'(bus.RAMSchreibenAn), 0);
    check("mid reset DatenGeladen", 32'(bus.DatenGeladen), 0);
    check("mid reset DatenLesewert", bus.DatenLesewert, 0);
    bus.DatenLesen = 0;
    idle(2);
    Reset = 1;
    idle(3);
    ackDelay = 2;
    expRam(0, 8'h05, 0, 2); expDone(4'b1000, 32'hDEADBEEF);
    fetch(1, 8'h05);
    idle(1);

    // read and write together act as a write
    ackDelay = 2;
    expRam(1, 8'h60, 32'hA5A5A5A5, 2); expDone(4'b0010, 0);
    datenZugriff(1, 1, 8'h60, 32'hA5A5A5A5);
    idle(3);

    check("InstrDaten holds", bus.InstrDaten, 32'hDEADBEEF);
    check("DatenLesewert holds", bus.DatenLesewert, 32'h0);
    check("ram mem written", mem[8'h60], 32'hA5A5A5A5);
    check("pending done expectations", 32'(doneQ.size()), 0);
    check("pending ram expectations", 32'(ramQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/speicher_arbiter.md
SPEICHER_ARBITER -- requirements
Module: speicher_arbiter

Interface
REQ-001 Parameter WORDSIZE, default 32, data word width of all data ports.
REQ-002 Parameter ADRESSBREITE, default 8, address width of all address ports.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles a RAM access may stay open before it is aborted.
REQ-004 Clock  in  1  single clock; all state changes on the rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 InstrLesen  in  1  instruction fetch request (level).
REQ-007 InstrAdresse  in  ADRESSBREITE  fetch address.
REQ-008 InstrDaten  out  WORDSIZE  fetched word, valid while InstrGeladen=1.
REQ-009 InstrGeladen  out  1  one-cycle fetch-done pulse.
REQ-010 DatenLesen / DatenSchreiben  in  1 each  data read / write request (level).
REQ-011 DatenAdresse  in  ADRESSBREITE; DatenSchreibwert  in  WORDSIZE  data-port address and write value.
REQ-012 DatenLesewert  out  WORDSIZE  read word, valid while DatenGeladen=1.
REQ-013 DatenGeladen / DatenGespeichert  out  1 each  one-cycle read-done / write-done pulse.
REQ-014 RAMLesenAn / RAMSchreibenAn  out  1 each  read / write strobe to the shared RAM.
REQ-015 RAMAdresse  out  ADRESSBREITE; RAMDatenRein  out  WORDSIZE  address and write data to the RAM.
REQ-016 RAMDatenRaus  in  WORDSIZE; RAMDatenBereit / RAMDatenGeschrieben  in  1 each  RAM read data and read / write acknowledge.
REQ-017 Zeitueberschreitung  out  1  one-cycle pulse when an access is aborted by timeout.

Function
REQ-018 States: FREI, ZUGRIFF, ABSCHLUSS.
REQ-019 FREI: if any request is high, the block latches the winner, its address and its write value at the clock edge, and enters ZUGRIFF.
REQ-020 Arbitration on conflict (instruction and data pending in the same FREI cycle): the requester not served last wins.
REQ-021 Arbitration register Letzter is updated on every grant.
REQ-022 DatenLesen=1 and DatenSchreiben=1 together are treated as a write.
REQ-023 ZUGRIFF: exactly one RAM strobe is high, driven from registered values; RAMAdresse and RAMDatenRein stay constant; requester inputs are ignored.
REQ-024 ZUGRIFF: on the matching acknowledge (RAMDatenBereit for a read, RAMDatenGeschrieben for a write), RAMDatenRaus is registered, the strobe drops and the state becomes ABSCHLUSS.
REQ-025 ABSCHLUSS lasts exactly one cycle.
REQ-026 ABSCHLUSS: the served requester's done pulse is high.
REQ-027 ABSCHLUSS: for reads, InstrDaten or DatenLesewert carries the registered word.
REQ-028 ABSCHLUSS: all requests are ignored; the next state is FREI.
REQ-029 Latency: request first high in cycle N with the block in FREI gives strobe high N+1 to M, acknowledge in M, done pulse in M+1, and earliest next grant at the edge ending M+2.
REQ-030 Requesters deassert their request in the cycle after their done pulse; a request still high in FREI is a new access.
REQ-031 Timeout counter: cleared on entry to ZUGRIFF and incremented each ZUGRIFF cycle without acknowledge.
REQ-032 On reaching TIMEOUT, the strobe drops and the state becomes ABSCHLUSS with the requester's done pulse asserted, read data forced to 0, and Zeitueberschreitung high for that cycle.
REQ-033 An acknowledge in the same cycle the counter reaches TIMEOUT counts as success; no timeout is flagged.
REQ-034 Acknowledges outside ZUGRIFF, and the non-matching acknowledge during ZUGRIFF, are ignored.
REQ-035 InstrDaten and DatenLesewert hold their last value outside done pulses.

Reset
REQ-036 Reset=0 immediately forces state FREI and clears all strobes, done pulses and Zeitueberschreitung, asynchronously.
REQ-037 Reset=0 clears the counter, InstrDaten, DatenLesewert and RAMAdresse/RAMDatenRein to 0, and sets Letzter to data, so the first conflict grants instruction.
REQ-038 Reset mid-access discards the access; no done pulse is issued for it after release.
REQ-039 First grant possible at the first rising edge with Reset=1.

Verification
REQ-040 Fetch only: InstrLesen=1, InstrAdresse=0x05, RAM acks one cycle after strobe with 0xDEADBEEF -> RAMLesenAn high 2 cycles, InstrGeladen pulse with InstrDaten=0xDEADBEEF.
REQ-041 Conflict after reset: InstrLesen and DatenLesen high same cycle -> fetch served first, then data read; second conflict in the same order -> data first.
REQ-042 Write: DatenSchreiben=1, DatenAdresse=0x10, DatenSchreibwert=0x0000000F -> RAMSchreibenAn with RAMAdresse=0x10, RAMDatenRein=0x0F, DatenGespeichert pulse after RAMDatenGeschrieben.
REQ-043 Timeout: data read, RAM never acks, TIMEOUT=15 -> strobe drops after 15 ZUGRIFF cycles, DatenGeladen and Zeitueberschreitung pulse together, DatenLesewert=0.
REQ-044 Reset mid-access: assert Reset=0 during ZUGRIFF, then release -> strobes low immediately, no done pulse, the next request is granted normally.
REQ-045 Read+write together: DatenLesen=DatenSchreiben=1 -> only RAMSchreibenAn asserted, DatenGespeichert pulse, no DatenGeladen.
